// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory: FSM states, default
// geometry and the byte-lane rotation used to align misaligned words to banks.
package dmem_pkg;

   localparam int DMEM_DEPTH_BYTES = 1024;
   localparam int DMEM_DATA_W      = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT2 = 2'd1,
      ST_RESP  = 2'd2
   } dmem_state_e;

   // Byte rotation expressed per lane: output lane 'lane' takes input lane
   // (lane + shift) mod lanes. Rotating right by the address offset maps banks
   // to result bytes; rotating by (lanes - offset) maps request bytes to banks.
   function automatic int byte_rot_src(input int lane, input int shift, input int lanes);
      return (lane + shift) % lanes;
   endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte-wide bank: synchronous write, registered read. The read register
// only updates on a read strobe so its value is stable between reads.
module dmem_byte_bank #(
   parameter int ROWS  = 256,
   parameter int ROW_W = $clog2(ROWS)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [ROW_W-1:0] row_i,
   input  logic [7:0]       wdata_i,
   output logic [7:0]       rdata_o
);

   logic [7:0] mem_q [ROWS];
   logic [7:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[row_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[row_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_data_memory.sv
// Byte-banked data memory with one outstanding request. Build with
// DMEM_MISALIGN_EN to split misaligned accesses over two beats; otherwise
// they are rejected with rsp_err.
module banked_data_memory
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES = DMEM_DEPTH_BYTES,
   parameter int DATA_W      = DMEM_DATA_W,
   parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   input  logic [DATA_W/8-1:0]  req_be,
   output logic                 rsp_valid,
   output logic [DATA_W-1:0]    rsp_rdata,
   output logic                 rsp_err,
   output dmem_state_e          dbg_state
);

   localparam int BANKS = DATA_W / 8;
   localparam int ROWS  = DEPTH_BYTES / BANKS;
   localparam int OFF_W = $clog2(BANKS);
   localparam int ROW_W = ADDR_W - OFF_W;
`ifdef DMEM_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   dmem_state_e state_q, state_d;
   logic              init_q;
   logic [OFF_W-1:0]  off_q;
   logic [ROW_W-1:0]  row_q;
   logic              write_q, err_q, zero_q;
   logic [DATA_W-1:0] wdata_q, hold_q;
   logic [BANKS-1:0]  be_q;

   logic [OFF_W-1:0]  off;
   logic [ROW_W-1:0]  row;
   logic              accept, misaligned, reject;
   logic [DATA_W-1:0] wdata_rot, bank_dout, rdata_live;
   logic [BANKS-1:0]  be_rot, bank_we, bank_re;
   logic [ROW_W-1:0]  bank_row [BANKS];
   logic [7:0]        bank_wdata [BANKS];

   assign off        = req_addr[OFF_W-1:0];
   assign row        = req_addr[ADDR_W-1:OFF_W];
   assign misaligned = (off != '0);
   assign reject     = misaligned && !MIS_EN;
   assign accept     = req_valid && init_q && (state_q == ST_IDLE);
   assign dbg_state  = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = (misaligned && MIS_EN) ? ST_BEAT2 : ST_RESP;
         ST_BEAT2: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Lower-row banks (lane >= offset) are touched on acceptance, upper-row
   // banks (lane < offset) in BEAT2; aligned accesses touch every bank at once.
   always_comb begin
      req_ready = init_q && (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
      rsp_err   = rsp_valid && err_q;
      bank_we   = '0;
      bank_re   = '0;
      for (int b = 0; b < BANKS; b++) begin
         bank_row[b]   = row;
         bank_wdata[b] = wdata_rot[b*8 +: 8];
         case (state_q)
            ST_IDLE: begin
               if (accept && !reject && (OFF_W'(b) >= off)) begin
                  bank_we[b] = req_write && be_rot[b];
                  bank_re[b] = !req_write;
               end
            end
            ST_BEAT2: begin
               bank_row[b]   = row_q;
               bank_wdata[b] = wdata_q[b*8 +: 8];
               if (OFF_W'(b) < off_q) begin
                  bank_we[b] = write_q && be_q[b];
                  bank_re[b] = !write_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wdata_rot  = '0;
      be_rot     = '0;
      rdata_live = '0;
      for (int b = 0; b < BANKS; b++) begin
         wdata_rot[b*8 +: 8] = req_wdata[byte_rot_src(b, BANKS - int'(off), BANKS)*8 +: 8];
         be_rot[b]           = req_be[byte_rot_src(b, BANKS - int'(off), BANKS)];
         rdata_live[b*8 +: 8] = bank_dout[byte_rot_src(b, int'(off_q), BANKS)*8 +: 8];
      end
      if (zero_q) rdata_live = '0;
   end

   // Outside RESP the last response is replayed from hold_q so rsp_rdata does
   // not follow bank reads of the next request.
   assign rsp_rdata = (state_q == ST_RESP) ? rdata_live : hold_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         off_q   <= '0;
         row_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         zero_q  <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         hold_q  <= '0;
      end else begin
         if (accept) begin
            off_q   <= off;
            row_q   <= row + ROW_W'(1);
            write_q <= req_write;
            err_q   <= reject;
            zero_q  <= req_write || reject;
            wdata_q <= wdata_rot;
            be_q    <= be_rot;
         end
         if (state_q == ST_RESP) hold_q <= rdata_live;
      end
   end

   for (genvar g = 0; g < BANKS; g++) begin : g_bank
      dmem_byte_bank #(.ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
         .clk_i   (clk),
         .we_i    (bank_we[g]),
         .re_i    (bank_re[g]),
         .row_i   (bank_row[g]),
         .wdata_i (bank_wdata[g]),
         .rdata_o (bank_dout[g*8 +: 8])
      );
   end

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed bench for banked_data_memory; misaligned cases follow DMEM_MISALIGN_EN.
module tb_banked_data_memory;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   dmem_state_e dbg_state;

   int tests = 0;
   int failed = 0;
   int got_lat;
   logic [31:0] got_rdata;
   logic        got_err;

   banked_data_memory dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request, returns at the negedge where rsp_valid is seen.
   task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      tests++;
      assert (n < 20) else begin failed++; $error("FAIL ready_timeout: observed %0d expected <20", n); end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      got_lat = 1;
      while (!rsp_valid && got_lat < 10) begin @(negedge clk); got_lat++; end
      tests++;
      assert (got_lat < 10) else begin failed++; $error("FAIL rsp_timeout: observed %0d expected <10", got_lat); end
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rdata", rsp_rdata, 32'h0);
      reset = 1'b1;
      #1 check("ready_before_edge", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(req_ready), 32'd1);

      issue(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
      check("wr010_lat", 32'(got_lat), 32'd1);
      check("wr010_rdata", got_rdata, 32'h0);
      check("wr010_err", 32'(got_err), 32'd0);
      issue(1'b0, 10'h010, 32'h0, 4'h0);
      check("rd010_lat", 32'(got_lat), 32'd1);
      check("rd010_rdata", got_rdata, 32'hDEADBEEF);
      check("rd010_err", 32'(got_err), 32'd0);
      @(negedge clk);
      check("pulse_one_cycle", 32'(rsp_valid), 32'd0);
      check("rdata_hold", rsp_rdata, 32'hDEADBEEF);

      issue(1'b1, 10'h020, 32'h11223344, 4'hF);
      issue(1'b1, 10'h020, 32'h0000AA00, 4'b0010);
      issue(1'b0, 10'h020, 32'h0, 4'hF);
      check("rd020_be_merge", got_rdata, 32'h1122AA44);

      issue(1'b1, 10'h030, 32'h0, 4'hF);
      issue(1'b1, 10'h030, 32'hFFFFFFFF, 4'b1001);
      issue(1'b0, 10'h030, 32'h0, 4'h0);
      check("rd030_be_edges", got_rdata, 32'hFF0000FF);

`ifdef DMEM_MISALIGN_EN
      issue(1'b1, 10'h100, 32'h0, 4'hF);
      issue(1'b1, 10'h104, 32'h0, 4'hF);
      issue(1'b1, 10'h101, 32'hCAFEF00D, 4'hF);
      check("mis_wr_lat", 32'(got_lat), 32'd2);
      check("mis_wr_rdata", got_rdata, 32'h0);
      check("mis_wr_err", 32'(got_err), 32'd0);
      issue(1'b0, 10'h101, 32'h0, 4'h0);
      check("mis_rd_lat", 32'(got_lat), 32'd2);
      check("mis_rd_rdata", got_rdata, 32'hCAFEF00D);
      issue(1'b0, 10'h100, 32'h0, 4'h0);
      check("rd100_rdata", got_rdata, 32'hFEF00D00);
      issue(1'b0, 10'h104, 32'h0, 4'h0);
      check("rd104_rdata", got_rdata, 32'h000000CA);
      issue(1'b1, 10'h101, 32'hFFFFFFFF, 4'b0001);
      issue(1'b0, 10'h100, 32'h0, 4'h0);
      check("mis_be_rdata", got_rdata, 32'hFEF0FF00);

      issue(1'b1, 10'h000, 32'hA5A5A5A5, 4'hF);
      issue(1'b1, 10'h3FC, 32'h5A5A5A5A, 4'hF);
      issue(1'b1, 10'h3FE, 32'h01020304, 4'hF);
      issue(1'b0, 10'h000, 32'h0, 4'h0);
      check("wrap_low_rdata", got_rdata, 32'hA5A50102);
      issue(1'b0, 10'h3FC, 32'h0, 4'h0);
      check("wrap_high_rdata", got_rdata, 32'h03045A5A);
      issue(1'b0, 10'h3FE, 32'h0, 4'h0);
      check("wrap_mis_rdata", got_rdata, 32'h01020304);

      issue(1'b1, 10'h200, 32'h0, 4'hF);
      issue(1'b1, 10'h204, 32'h0, 4'hF);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h201; req_wdata = 32'h44332211; req_be = 4'hF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("beat2_state", 32'(dbg_state), 32'(ST_BEAT2));
      reset = 1'b0;
      #1;
      check("abort_ready", 32'(req_ready), 32'd0);
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      begin
         int seen = 0;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
         end
         check("abort_no_rsp", 32'(seen), 32'd0);
      end
      reset = 1'b1;
      #1 check("abort_ready_release", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("abort_ready_rise", 32'(req_ready), 32'd1);
      check("abort_no_rsp_after", 32'(rsp_valid), 32'd0);
      issue(1'b0, 10'h200, 32'h0, 4'h0);
      check("abort_beat1_kept", got_rdata, 32'h33221100);
      issue(1'b0, 10'h204, 32'h0, 4'h0);
      check("abort_beat2_skipped", got_rdata, 32'h00000000);
`else
      issue(1'b1, 10'h000, 32'hA5A5A5A5, 4'hF);
      issue(1'b1, 10'h003, 32'h12345678, 4'hF);
      check("mis_wr_lat", 32'(got_lat), 32'd1);
      check("mis_wr_err", 32'(got_err), 32'd1);
      check("mis_wr_rdata", got_rdata, 32'h0);
      issue(1'b0, 10'h000, 32'h0, 4'h0);
      check("rd000_unchanged", got_rdata, 32'hA5A5A5A5);
      check("rd000_err", 32'(got_err), 32'd0);
      issue(1'b1, 10'h004, 32'h0, 4'hF);
      issue(1'b1, 10'h001, 32'hFFFFFFFF, 4'hF);
      issue(1'b0, 10'h004, 32'h0, 4'h0);
      check("rd004_unchanged", got_rdata, 32'h0);
      issue(1'b0, 10'h002, 32'h0, 4'h0);
      check("mis_rd_err", 32'(got_err), 32'd1);
      check("mis_rd_rdata", got_rdata, 32'h0);
`endif

      issue(1'b0, 10'h010, 32'h0, 4'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst2_rdata", rsp_rdata, 32'h0);
      check("rst2_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst2_ready_rise", 32'(req_ready), 32'd1);
      issue(1'b0, 10'h010, 32'h0, 4'h0);
      check("mem_survives_reset", got_rdata, 32'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
